// File: rtl/gate_pkg.sv
// Shared types and bitwise helpers for the gate stream reducer.
// Latency: none; constants, enums and pure functions only.
// Backpressure: not applicable.
package gate_pkg;

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_XOR  = 3'd2,
    OP_NAND = 3'd3,
    OP_NOR  = 3'd4,
    OP_XNOR = 3'd5,
    OP_RSV6 = 3'd6,
    OP_RSV7 = 3'd7
  } op_e;

  // Underlying reduction operator; inversion is tracked separately.
  typedef enum logic [1:0] {
    BASE_AND = 2'd0,
    BASE_OR  = 2'd1,
    BASE_XOR = 2'd2
  } base_e;

  // Codes above this value are reserved and flag an error on emit.
  localparam logic [2:0] OP_MAX_LEGAL = 3'd5;

  // Reserved codes fall back to AND so the data path is still well defined.
  function automatic base_e base_of(op_e op);
    case (op)
      OP_OR, OP_NOR:   return BASE_OR;
      OP_XOR, OP_XNOR: return BASE_XOR;
      default:         return BASE_AND;
    endcase
  endfunction

  function automatic logic inv_of(op_e op);
    return (op == OP_NAND) || (op == OP_NOR) || (op == OP_XNOR);
  endfunction

  // Fill bit of the accumulator identity: all-ones for AND-based ops,
  // zero otherwise. Callers replicate it to the datapath width.
  function automatic logic identity(op_e op);
    return base_of(op) == BASE_AND;
  endfunction

  // Single-bit base operator, shared by lane reduction and beat folding.
  function automatic logic base_bit(base_e b, logic x, logic y);
    case (b)
      BASE_OR:  return x | y;
      BASE_XOR: return x ^ y;
      default:  return x & y;
    endcase
  endfunction

endpackage

// File: rtl/gate_lane_reduce.sv
// Reduces N lanes of W bits to one W-bit word with the selected base op.
// Latency: purely combinational.
// Backpressure: none; follows its inputs.
module gate_lane_reduce
  import gate_pkg::*;
#(
  parameter int W = 8,
  parameter int N = 2
) (
  input  logic [N*W-1:0] lanes,
  input  base_e          base,
  output logic [W-1:0]   result
);

  // Fold lanes 1..N-1 onto lane 0, bit by bit.
  always_comb begin
    result = lanes[W-1:0];
    for (int k = 1; k < N; k++) begin
      for (int b = 0; b < W; b++) begin
        result[b] = base_bit(base, result[b], lanes[k*W + b]);
      end
    end
  end

endmodule

// File: rtl/gate_stream_reducer.sv
// Reduces lanes of each beat and folds beats across a packet into one W-bit result.
// Latency: result valid one cycle after the last beat is accepted.
// Backpressure: in_ready = !out_valid || out_ready; a held result stalls every beat.
module gate_stream_reducer
  import gate_pkg::*;
#(
  parameter int W     = 8,
  parameter int N     = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       op,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N*W-1:0]   in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic [CNT_W-1:0] out_beats,
  output logic             out_err
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_ACC  = 1'b1
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e           state;
  state_e           state_nxt;
  op_e              op_q;
  op_e              op_cur;
  base_e            base_cur;
  logic [W-1:0]     acc;
  logic [W-1:0]     acc_src;
  logic [W-1:0]     lane_red;
  logic [W-1:0]     fold_val;
  logic [W-1:0]     final_val;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             accept;
  logic             take;
  logic             emit;
  logic             is_err;

  // Ready depends only on the output register and the downstream ready.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign take     = out_valid && out_ready;
  assign emit     = accept && in_last;

  // The op is taken live on a packet's first beat, then held for the rest.
  assign op_cur   = (state == S_IDLE) ? op_e'(op) : op_q;
  assign base_cur = base_of(op_cur);
  assign is_err   = 3'(op_cur) > OP_MAX_LEGAL;

  gate_lane_reduce #(
    .W(W),
    .N(N)
  ) u_lane_reduce (
    .lanes  (in_data),
    .base   (base_cur),
    .result (lane_red)
  );

  // A fresh packet folds onto the identity so first and later beats share one path.
  assign acc_src = (state == S_IDLE) ? {W{identity(op_cur)}} : acc;

  // Fold the reduced beat into the running accumulator.
  always_comb begin
    fold_val = '0;
    for (int b = 0; b < W; b++) begin
      fold_val[b] = base_bit(base_cur, acc_src[b], lane_red[b]);
    end
  end

  // Inversion is applied once to the packet result; reserved ops emit zero.
  assign final_val = is_err ? '0 : (inv_of(op_cur) ? ~fold_val : fold_val);

  // Beat count including the current beat, sticking at the maximum.
  always_comb begin
    cnt_nxt = cnt;
    if (state == S_IDLE) begin
      cnt_nxt = CNT_ONE;
    end else if (cnt != CNT_MAX) begin
      cnt_nxt = cnt + CNT_ONE;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: a last beat closes the packet, any other beat leaves it open.
  always_comb begin
    state_nxt = state;
    if (accept) begin
      state_nxt = in_last ? S_IDLE : S_ACC;
    end
  end

  // Accumulator, beat counter and latched op advance on each accepted beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc  <= '0;
      cnt  <= '0;
      op_q <= OP_AND;
    end else if (accept) begin
      if (state == S_IDLE) begin
        op_q <= op_e'(op);
      end
      acc <= fold_val;
      cnt <= cnt_nxt;
    end
  end

  // Output register: load on emit (even while a take happens), clear valid on take.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_beats <= '0;
      out_err   <= 1'b0;
    end else if (emit) begin
      out_valid <= 1'b1;
      out_data  <= final_val;
      out_beats <= cnt_nxt;
      out_err   <= is_err;
    end else if (take) begin
      out_valid <= 1'b0;
    end
  end

endmodule
